// File: rtl/tile_stream_unpacker.sv
// Tile stream unpacker: scatters AXI read beats into a ROWS x COLS grid of bank lanes (A/B/C layouts).
// Optional macro TILE_LAST_CHECK_EN flags in_last misplacement on the sticky err output.

module tsu_lane #(
  parameter int BUS_W    = 256,
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int LANE_W   = 32,
  parameter int LANE_IDX = 0,
  parameter int BCW      = 4
) (
  input  logic [BUS_W-1:0]    in_data,
  input  logic [BCW-1:0]      beat,
  input  logic [1:0]          dtype,
  input  logic [1:0]          mat,
  output logic                lane_en,
  output logic [LANE_W/4-1:0] nib_en,
  output logic [LANE_W-1:0]   data
);
  localparam int NIB   = LANE_W / 4;
  localparam int L     = ROWS * COLS;
  localparam int NC    = BUS_W / LANE_W;
  localparam bit C_OK  = NC > 0;
  localparam int NCS   = C_OK ? NC : 1;
  localparam int C_BT  = LANE_IDX / NCS;
  localparam int C_I   = LANE_IDX % NCS;
  localparam int ROW   = LANE_IDX / COLS;
  localparam int COL   = LANE_IDX % COLS;

  logic [NIB-1:0]           a_en;
  logic [NIB-1:0][3:0]      a_nib;
  logic [NIB-1:0][3:0]      b_en;
  logic [NIB-1:0][3:0][3:0] b_nib;
  logic                     c_en;
  logic [3:0][LANE_W-1:0]   c_data;
  logic                     unused_in;

  assign unused_in = ^in_data;

  // Each lane nibble is inverted back to the (beat, bit) it comes from, so selection is a constant compare.
  genvar n, d;
  for (n = 0; n < NIB; n++) begin : g_nib
    localparam int A_POS = LANE_IDX * LANE_W + n * 4;
    assign a_en[n]  = (int'(beat) == A_POS / BUS_W);
    assign a_nib[n] = in_data[A_POS % BUS_W +: 4];
    for (d = 0; d < 4; d++) begin : g_dt
      localparam int EW    = 32 >> d;
      localparam int E     = BUS_W / EW;
      localparam int G     = ((n * 4) / EW) * L + COL * ROWS + ROW;
      localparam int B_BIT = (G % E) * EW + (n * 4) % EW;
      assign b_en[n][d]  = (int'(beat) == G / E);
      assign b_nib[n][d] = in_data[B_BIT +: 4];
    end
  end

  assign c_en = C_OK && (int'(beat) == C_BT);
  for (d = 0; d < 4; d++) begin : g_c
    localparam int EW = 32 >> d;
    if (C_OK && (C_I + 1) * EW <= BUS_W) begin : g_src
      logic [EW-1:0] elem;
      assign elem = in_data[C_I*EW +: EW];
      if (EW >= LANE_W) begin : g_trunc
        assign c_data[d] = elem[LANE_W-1:0];
      end else if (d >= 2) begin : g_sext
        assign c_data[d] = {{(LANE_W-EW){elem[EW-1]}}, elem};
      end else begin : g_zext
        assign c_data[d] = {{(LANE_W-EW){1'b0}}, elem};
      end
    end else begin : g_none
      assign c_data[d] = '0;
    end
  end

  always_comb begin
    nib_en = '0;
    data   = '0;
    case (mat)
      2'd0: for (int i = 0; i < NIB; i++) if (a_en[i]) begin
        nib_en[i] = 1'b1;
        data[i*4 +: 4] = a_nib[i];
      end
      2'd1: for (int i = 0; i < NIB; i++) if (b_en[i][dtype]) begin
        nib_en[i] = 1'b1;
        data[i*4 +: 4] = b_nib[i][dtype];
      end
      2'd2: if (c_en) begin
        nib_en = '1;
        data   = c_data[dtype];
      end
      default: ;
    endcase
  end

  assign lane_en = |nib_en;
endmodule

module tile_stream_unpacker #(
  parameter int BUS_W  = 256,
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int LANE_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [1:0]                    cfg_dtype,
  input  logic [1:0]                    cfg_mat,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BUS_W-1:0]              in_data,
  input  logic                          in_last,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ROWS*COLS-1:0]          wr_lane_en,
  output logic [ROWS*COLS*LANE_W/4-1:0] wr_nib_en,
  output logic [ROWS*COLS*LANE_W-1:0]   wr_data,
  output logic                          tile_done,
  output logic                          busy,
  output logic                          err
);
  localparam int L     = ROWS * COLS;
  localparam int NIB   = LANE_W / 4;
  localparam int BEATS = L * LANE_W / BUS_W;
  localparam int BCW   = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [BCW-1:0]          beat_cnt_q, beat_cnt_d;
  logic [1:0]              dtype_q, dtype_d, mat_q, mat_d;
  logic                    err_q, err_d, tile_done_q, tile_done_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [L-1:0]            wr_lane_en_q, wr_lane_en_d;
  logic [L*NIB-1:0]        wr_nib_en_q, wr_nib_en_d;
  logic [L*LANE_W-1:0]     wr_data_q, wr_data_d;
  logic                    accept, last_beat;

  logic [L-1:0]             map_lane_en;
  logic [L-1:0][NIB-1:0]    map_nib_en;
  logic [L-1:0][LANE_W-1:0] map_data;

  genvar l;
  for (l = 0; l < L; l++) begin : g_lane
    tsu_lane #(
      .BUS_W(BUS_W), .ROWS(ROWS), .COLS(COLS), .LANE_W(LANE_W), .LANE_IDX(l), .BCW(BCW)
    ) u_lane (
      .in_data(in_data), .beat(beat_cnt_q), .dtype(dtype_q), .mat(mat_q),
      .lane_en(map_lane_en[l]), .nib_en(map_nib_en[l]), .data(map_data[l])
    );
  end

`ifndef TILE_LAST_CHECK_EN
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  assign last_beat = (beat_cnt_q == BCW'(BEATS - 1));

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    dtype_d      = dtype_q;
    mat_d        = mat_q;
    err_d        = err_q;
    tile_done_d  = 1'b0;
    wr_valid_d   = wr_valid_q;
    wr_lane_en_d = wr_lane_en_q;
    wr_nib_en_d  = wr_nib_en_q;
    wr_data_d    = wr_data_q;
    cfg_ready    = (state_q == IDLE);
    in_ready     = (state_q == LOAD) && (!wr_valid_q || wr_ready);
    accept       = in_valid && in_ready;

    case (state_q)
      IDLE: if (cfg_valid) begin
        if (cfg_mat == 2'd3) begin
          err_d = 1'b1;
        end else begin
          dtype_d    = cfg_dtype;
          mat_d      = cfg_mat;
          beat_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: if (accept) begin
        beat_cnt_d = beat_cnt_q + BCW'(1);
        if (last_beat) state_d = DRAIN;
      end
      DRAIN: if (wr_valid_q && wr_ready) begin
        tile_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Output register: refill on accept, drop on drain, otherwise hold under backpressure.
    if (accept) begin
      wr_valid_d   = 1'b1;
      wr_lane_en_d = map_lane_en;
      wr_nib_en_d  = map_nib_en;
      wr_data_d    = map_data;
    end else if (wr_ready) begin
      wr_valid_d   = 1'b0;
      wr_lane_en_d = '0;
      wr_nib_en_d  = '0;
      wr_data_d    = '0;
    end

`ifdef TILE_LAST_CHECK_EN
    if (accept && (in_last != last_beat)) err_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      dtype_q      <= 2'd0;
      mat_q        <= 2'd0;
      err_q        <= 1'b0;
      tile_done_q  <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_lane_en_q <= '0;
      wr_nib_en_q  <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      dtype_q      <= dtype_d;
      mat_q        <= mat_d;
      err_q        <= err_d;
      tile_done_q  <= tile_done_d;
      wr_valid_q   <= wr_valid_d;
      wr_lane_en_q <= wr_lane_en_d;
      wr_nib_en_q  <= wr_nib_en_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_lane_en = wr_lane_en_q;
  assign wr_nib_en  = wr_nib_en_q;
  assign wr_data    = wr_data_q;
  assign tile_done  = tile_done_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
endmodule

// File: tb/tb_tile_stream_unpacker.sv
// Scoreboard bench for tile_stream_unpacker: stimulus pushes expected writes, a negedge monitor pops/compares.
module tb_tile_stream_unpacker;
  localparam int BUS_W = 256, ROWS = 8, COLS = 8, LANE_W = 32;
  localparam int L = ROWS * COLS;
`ifdef TILE_LAST_CHECK_EN
  localparam logic LAST_CHK = 1'b1;
`else
  localparam logic LAST_CHK = 1'b0;
`endif

  typedef struct {
    logic [L-1:0]          lane_en;
    logic [L*LANE_W/4-1:0] nib_en;
    logic [L*LANE_W-1:0]   data;
  } exp_t;

  logic                   clk = 0, rst_n = 0;
  logic                   cfg_valid = 0, cfg_ready;
  logic [1:0]             cfg_dtype = 0, cfg_mat = 0;
  logic                   in_valid = 0, in_ready, in_last = 0;
  logic [BUS_W-1:0]       in_data = '0;
  logic                   wr_valid, wr_ready = 1;
  logic [L-1:0]           wr_lane_en;
  logic [L*LANE_W/4-1:0]  wr_nib_en;
  logic [L*LANE_W-1:0]    wr_data;
  logic                   tile_done, busy, err;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, wr_cnt = 0, done_cnt = 0, first_wr_cyc = 0, last_wr_cyc = 0;

  tile_stream_unpacker dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_dtype(cfg_dtype), .cfg_mat(cfg_mat), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_lane_en(wr_lane_en), .wr_nib_en(wr_nib_en), .wr_data(wr_data),
    .tile_done(tile_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endfunction

  function automatic void chk_data(input string nm, input logic [L*LANE_W-1:0] got,
                                   input logic [L*LANE_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      for (int l = 0; l < L; l++)
        if (got[l*LANE_W +: LANE_W] !== exp[l*LANE_W +: LANE_W]) begin
          $display("FAIL %s lane %0d got=%h exp=%h", nm, l, got[l*LANE_W +: LANE_W], exp[l*LANE_W +: LANE_W]);
          break;
        end
    end
  endfunction

  function automatic void chk_nib(input string nm, input logic [L*LANE_W/4-1:0] got,
                                  input logic [L*LANE_W/4-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endfunction

  // Forward mapping: element -> (lane, slot).
  function automatic exp_t model(input int mat, input int dt, input int k, input logic [BUS_W-1:0] d);
    exp_t e;
    int ew, ne, s, g, lane, slot;
    logic [31:0] el;
    e.lane_en = '0; e.nib_en = '0; e.data = '0;
    ew = 32 >> dt; ne = BUS_W / ew; s = LANE_W / ew;
    if (mat == 2) begin
      for (int i = 0; i < BUS_W / LANE_W; i++) begin
        lane = k * (BUS_W / LANE_W) + i;
        el = '0;
        for (int b = 0; b < ew; b++) el[b] = d[i*ew + b];
        if (dt >= 2) for (int b = ew; b < 32; b++) el[b] = el[ew-1];
        e.lane_en[lane] = 1'b1;
        for (int n = 0; n < LANE_W / 4; n++) e.nib_en[lane*(LANE_W/4) + n] = 1'b1;
        for (int b = 0; b < LANE_W; b++) e.data[lane*LANE_W + b] = el[b];
      end
    end else begin
      for (int i = 0; i < ne; i++) begin
        g = k * ne + i;
        if (mat == 0) begin
          lane = g / s; slot = g % s;
        end else begin
          lane = (g % ROWS) * COLS + ((g / ROWS) % COLS); slot = g / L;
        end
        e.lane_en[lane] = 1'b1;
        for (int n = 0; n < ew / 4; n++) e.nib_en[lane*(LANE_W/4) + slot*(ew/4) + n] = 1'b1;
        for (int b = 0; b < ew; b++) e.data[lane*LANE_W + slot*ew + b] = d[i*ew + b];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_valid && wr_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_write", {127'd0, wr_valid}, 128'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_lane_en", wr_lane_en, e.lane_en);
          chk_nib("wr_nib_en", wr_nib_en, e.nib_en);
          chk_data("wr_data", wr_data, e.data);
        end
        wr_cnt++;
        if (wr_cnt == 1) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (tile_done) begin
        done_cnt++;
        chk("done_latency", cyc, last_wr_cyc + 1);
        chk("done_cfg_ready", cfg_ready, 1);
        chk("done_sb_empty", sb.size(), 0);
      end
    end
  end

  task automatic gen_beat(input int pat, input int k, output logic [BUS_W-1:0] d);
    d = '0;
    case (pat)
      1: for (int i = 0; i < 8; i++)  d[32*i +: 32] = 32'(k*8 + i);
      2: for (int i = 0; i < 64; i++) d[4*i +: 4]   = 4'((k + i) & 15);
      3: for (int i = 0; i < 32; i++) d[8*i +: 8]   = (i % 2 == 1) ? 8'(8'h7F - k) : 8'(8'h80 + k);
      4: for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'h8000 | 16'(k*8 + i);
      5: for (int i = 0; i < 32; i++) d[8*i +: 8]   = 8'(k*32 + i);
      6: for (int i = 0; i < 8; i++)  d[32*i +: 32] = 32'hA000_0000 + 32'(k*8 + i);
      default: for (int i = 0; i < 16; i++) d[16*i +: 16] = 16'h1000 + 16'(k*16 + i);
    endcase
  endtask

  task automatic send_beat(input logic [BUS_W-1:0] d, input logic last);
    int t;
    logic r;
    t = 0;
    in_valid = 1; in_data = d; in_last = last;
    forever begin
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) break;
      t++;
      if (t > 60) begin
        chk("beat_accept_timeout", {127'd0, r}, 128'd1);
        break;
      end
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic start_tile(input int mat, input int dt);
    int t;
    logic r;
    t = 0;
    cfg_valid = 1; cfg_mat = 2'(mat); cfg_dtype = 2'(dt);
    forever begin
      @(negedge clk); r = cfg_ready;
      @(posedge clk); #1;
      if (r || t > 20) break;
      t++;
    end
    chk("cfg_accepted", {127'd0, r}, 128'd1);
    cfg_valid = 0;
  endtask

  task automatic run_tile(input int mat, input int dt, input int pat, input bit bad_last);
    logic [BUS_W-1:0] d;
    int d0, t;
    wr_cnt = 0; d0 = done_cnt;
    start_tile(mat, dt);
    for (int k = 0; k < 8; k++) begin
      gen_beat(pat, k, d);
      sb.push_back(model(mat, dt, k, d));
      send_beat(d, bad_last ? (k == 2) : (k == 7));
    end
    t = 0;
    while (done_cnt == d0 && t < 100) begin @(posedge clk); t++; end
    repeat (2) @(posedge clk);
    #1;
    chk("tile_done_count", done_cnt - d0, 1);
    chk("tile_writes", wr_cnt, 8);
    chk("idle_busy", busy, 0);
  endtask

  task automatic stall();
    int t;
    logic [L*LANE_W-1:0] sd;
    logic [L*LANE_W/4-1:0] sn;
    logic [L-1:0] sl;
    t = 0;
    while (wr_cnt < 2 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1 wr_ready = 0;
    @(negedge clk);
    sd = wr_data; sn = wr_nib_en; sl = wr_lane_en;
    chk("stall_wr_valid", wr_valid, 1);
    chk("stall_in_ready", in_ready, 0);
    repeat (4) begin
      @(negedge clk);
      chk_data("stall_data_stable", wr_data, sd);
      chk_nib("stall_nib_stable", wr_nib_en, sn);
      chk("stall_lane_stable", wr_lane_en, sl);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1 wr_ready = 1;
  endtask

  initial begin
    logic [BUS_W-1:0] d;
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tile_done", tile_done, 0);
    chk("rst_err", err, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    chk_data("rst_wr_data", wr_data, '0);
    @(posedge clk); #1 rst_n = 1;

    run_tile(0, 0, 1, 0);
    chk("a_fp32_back_to_back", last_wr_cyc - first_wr_cyc, 7);
    run_tile(1, 3, 2, 0);
    run_tile(2, 2, 3, 0);
    run_tile(2, 1, 4, 0);
    wr_cnt = 0;
    fork
      run_tile(0, 2, 5, 0);
      stall();
    join
    chk("err_clean", err, 0);

    run_tile(1, 0, 6, 1);
    chk("err_last", err, LAST_CHK);
    repeat (3) @(posedge clk);
    #1 chk("err_last_sticky", err, LAST_CHK);

    // Abort after beat 3: the pending beat-3 write dies with reset.
    start_tile(0, 0);
    for (int k = 0; k < 4; k++) begin
      gen_beat(1, k, d);
      sb.push_back(model(0, 0, k, d));
      send_beat(d, 1'b0);
    end
    d0 = done_cnt;
    #2 rst_n = 0;
    #1;
    chk("arst_wr_valid", wr_valid, 0);
    chk("arst_lane_en", wr_lane_en, '0);
    chk_data("arst_wr_data", wr_data, '0);
    chk("arst_busy", busy, 0);
    chk("arst_tile_done", tile_done, 0);
    chk("arst_err", err, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    #1 chk("arst_no_done", done_cnt, d0);
    run_tile(1, 1, 7, 0);

    cfg_valid = 1; cfg_mat = 2'd3; cfg_dtype = 2'd0;
    @(posedge clk); #1 cfg_valid = 0;
    @(negedge clk);
    chk("rsv_err", err, 1);
    chk("rsv_busy", busy, 0);
    chk("rsv_cfg_ready", cfg_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
